// File: rtl/hypot_pkg.sv
// hypot_pkg: shared state encoding and width helpers for the magnitude unit
package hypot_pkg;
  typedef enum logic [1:0] {IDLE, SQUARE, ROOT, DONE} hypot_state_t;
  function automatic int ROOT_W(input int w);
    return w + 1;
  endfunction
  function automatic int SUM_W(input int w);
    return 2 * w + 1;
  endfunction
  function automatic int RAD_W(input int w);
    return 2 * w + 2;
  endfunction
  function automatic int ISQRT_ITERS(input int w);
    return w + 1;
  endfunction
endpackage

// File: rtl/isqrt_step.sv
// isqrt_step: one restoring square-root iteration, two radicand bits in, one root bit out
module isqrt_step #(
  parameter int W = 8
) (
  input  logic [W+1:0] i_rem,
  input  logic [W:0]   i_root,
  input  logic [1:0]   i_bits,
  output logic [W+1:0] o_rem,
  output logic [W:0]   o_root
);
  logic [W+3:0] w_cur;
  logic [W+3:0] w_sub;
  logic         w_ge;
  assign w_cur  = {i_rem, i_bits};
  assign w_sub  = {1'b0, i_root, 2'b01};
  assign w_ge   = w_cur >= w_sub;
  assign o_rem  = (W+2)'(w_ge ? w_cur - w_sub : w_cur);
  assign o_root = {i_root[W-1:0], w_ge};
endmodule

// File: rtl/hypot_seq.sv
// hypot_seq: sequential sqrt(x^2 + y^2) with floor/round, exact flag and valid/ready output
module hypot_seq
  import hypot_pkg::*;
#(
  parameter int W     = 8,
  parameter bit ROUND = 1'b0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           ena,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   x,
  input  logic [W-1:0]   y,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W:0]     root,
  output logic [2*W:0]   sum_sq,
  output logic           exact
);
  localparam int RW = ROOT_W(W);
  localparam int SW = SUM_W(W);
  localparam int DW = RAD_W(W);
  localparam int CW = $clog2(ISQRT_ITERS(W) + 1);

  hypot_state_t  r_state;
  logic [W-1:0]  r_x;
  logic [W-1:0]  r_y;
  logic [SW-1:0] r_sum;
  logic [RW:0]   r_rem;
  logic [RW-1:0] r_part;
  logic [CW-1:0] r_cnt;
  logic [RW-1:0] r_root;
  logic          r_exact;
  logic          r_valid;
  logic [SW-1:0] w_sq;
  logic [1:0]    w_bits;
  logic [RW:0]   w_rem;
  logic [RW-1:0] w_root;
  logic          w_inc;

  assign w_sq   = SW'(r_x) * SW'(r_x) + SW'(r_y) * SW'(r_y);
  assign w_bits = 2'(DW'(r_sum) >> {r_cnt, 1'b0});
  // (r+1/2)^2 = r^2 + r + 1/4, so an integer remainder above r rounds up
  assign w_inc  = ROUND && (w_rem > {1'b0, w_root});

  isqrt_step #(.W(W)) u_step (
    .i_rem  (r_rem),
    .i_root (r_part),
    .i_bits (w_bits),
    .o_rem  (w_rem),
    .o_root (w_root)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_x     <= '0;
      r_y     <= '0;
      r_sum   <= '0;
      r_rem   <= '0;
      r_part  <= '0;
      r_cnt   <= '0;
      r_root  <= '0;
      r_exact <= 1'b0;
      r_valid <= 1'b0;
    end else if (ena) begin
      case (r_state)
        IDLE: if (in_valid) begin
          r_x     <= x;
          r_y     <= y;
          r_state <= SQUARE;
        end
        SQUARE: begin
          r_sum   <= w_sq;
          r_rem   <= '0;
          r_part  <= '0;
          r_cnt   <= CW'(W);
          r_state <= ROOT;
        end
        ROOT: begin
          r_rem  <= w_rem;
          r_part <= w_root;
          r_cnt  <= r_cnt - 1'b1;
          if (r_cnt == '0) begin
            r_root  <= w_root + RW'(w_inc);
            r_exact <= w_rem == '0;
            r_valid <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: if (out_ready) begin
          r_valid <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = ena & (r_state == IDLE);
  assign out_valid = r_valid;
  assign root      = r_root;
  assign sum_sq    = r_sum;
  assign exact     = r_exact;
endmodule

// File: tb/tb_hypot_seq.sv
// tb_hypot_seq: scoreboard bench for hypot_seq (W=8 floor, W=12 floor and round)
module tb_hypot_seq;
  logic clk = 0, rst_n = 0, ena = 1;
  always #5 clk = ~clk;

  logic iv8 = 0, rdy8 = 1, ir8, ov8, ex8;
  logic [7:0] x8 = 0, y8 = 0;
  logic [8:0] root8;
  logic [16:0] sum8;
  logic iv12 = 0, rdy12 = 1, bp = 0, irf, irr, ovf, ovr, exf, exr;
  logic [11:0] x12 = 0, y12 = 0;
  logic [12:0] rootf, rootr;
  logic [24:0] sumf, sumr;

  hypot_seq #(.W(8), .ROUND(1'b0)) dut8 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .in_valid(iv8), .in_ready(ir8), .x(x8), .y(y8),
    .out_valid(ov8), .out_ready(rdy8), .root(root8), .sum_sq(sum8), .exact(ex8));
  hypot_seq #(.W(12), .ROUND(1'b0)) dutf (
    .clk(clk), .rst_n(rst_n), .ena(ena), .in_valid(iv12), .in_ready(irf), .x(x12), .y(y12),
    .out_valid(ovf), .out_ready(rdy12), .root(rootf), .sum_sq(sumf), .exact(exf));
  hypot_seq #(.W(12), .ROUND(1'b1)) dutr (
    .clk(clk), .rst_n(rst_n), .ena(ena), .in_valid(iv12), .in_ready(irr), .x(x12), .y(y12),
    .out_valid(ovr), .out_ready(rdy12), .root(rootr), .sum_sq(sumr), .exact(exr));

  typedef struct {int root; int sum; int ex;} exp_t;
  exp_t q8[$], qf[$], qr[$];
  exp_t e8, ef, er;
  int errs = 0, checks = 0;

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  // Reference: largest r with r*r <= s, then round up when s >= (r+1/2)^2
  function automatic exp_t model(input int a, input int b, input bit rnd);
    exp_t e;
    int s, r;
    s = a * a + b * b;
    r = 0;
    for (int k = 15; k >= 0; k--)
      if ((r + (1 << k)) * (r + (1 << k)) <= s) r += 1 << k;
    e.ex = (r * r == s);
    if (rnd && 4 * s >= (2 * r + 1) * (2 * r + 1)) r++;
    e.root = r;
    e.sum = s;
    return e;
  endfunction

  always @(negedge clk)
    if (rst_n && ena && ov8 && rdy8) begin
      if (q8.size() == 0) begin
        checks++; errs++;
        $display("FAIL out8 unexpected: got root %0d expected no output", root8);
      end else begin
        e8 = q8.pop_front();
        chk("root8", int'(root8), e8.root);
        chk("sum8", int'(sum8), e8.sum);
        chk("exact8", int'(ex8), e8.ex);
      end
    end

  always @(negedge clk)
    if (rst_n && ena && ovf && rdy12) begin
      if (qf.size() == 0) begin
        checks++; errs++;
        $display("FAIL outf unexpected: got root %0d expected no output", rootf);
      end else begin
        ef = qf.pop_front();
        chk("root12_floor", int'(rootf), ef.root);
        chk("sum12_floor", int'(sumf), ef.sum);
        chk("exact12_floor", int'(exf), ef.ex);
      end
    end

  always @(negedge clk)
    if (rst_n && ena && ovr && rdy12) begin
      if (qr.size() == 0) begin
        checks++; errs++;
        $display("FAIL outr unexpected: got root %0d expected no output", rootr);
      end else begin
        er = qr.pop_front();
        chk("root12_round", int'(rootr), er.root);
        chk("sum12_round", int'(sumr), er.sum);
        chk("exact12_round", int'(exr), er.ex);
      end
    end

  initial forever begin
    @(posedge clk);
    #1 rdy12 = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  task automatic issue8(input int a, input int b);
    int n = 0;
    q8.push_back(model(a, b, 1'b0));
    x8 = 8'(a); y8 = 8'(b); iv8 = 1;
    while (!ir8 && n < 200) begin @(posedge clk); #1; n++; end
    if (!ir8) chk("accept8_timeout", 0, 1);
    @(posedge clk); #1;
    iv8 = 0;
  endtask

  task automatic issue12(input int a, input int b);
    int n = 0;
    qf.push_back(model(a, b, 1'b0));
    qr.push_back(model(a, b, 1'b1));
    x12 = 12'(a); y12 = 12'(b); iv12 = 1;
    while (!(irf && irr) && n < 400) begin @(posedge clk); #1; n++; end
    if (!(irf && irr)) chk("accept12_timeout", 0, 1);
    @(posedge clk); #1;
    iv12 = 0;
  endtask

  initial begin
    int n;
    #12;
    chk("rst_valid", int'(ov8), 0);
    chk("rst_root", int'(root8), 0);
    chk("rst_sum", int'(sum8), 0);
    chk("rst_exact", int'(ex8), 0);
    chk("rst_in_ready", int'(ir8), 1);
    @(posedge clk); #1 rst_n = 1;

    issue8(3, 4);
    n = 0;
    while (!ov8 && n < 100) begin
      @(posedge clk); #1; n++;
      if (n == 1) chk("sum_after_edge1", int'(sum8), 25);
    end
    chk("latency8", n, 10);

    issue8(255, 255);
    issue8(0, 0);
    issue8(2, 3);
    issue8(5, 5);

    issue8(20, 21);
    rdy8 = 0;
    n = 0;
    while (!ov8 && n < 100) begin @(posedge clk); #1; n++; end
    iv8 = 1; x8 = 9; y8 = 9;
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", int'(ov8), 1);
      chk("hold_root", int'(root8), 29);
      chk("hold_sum", int'(sum8), 841);
      chk("hold_in_ready", int'(ir8), 0);
      @(posedge clk); #1;
    end
    rdy8 = 1;
    @(posedge clk); #1;
    chk("xfer_valid_clear", int'(ov8), 0);
    chk("xfer_in_ready_next", int'(ir8), 1);
    iv8 = 0;

    issue8(255, 255);
    n = 0;
    while (!ov8 && n < 100) begin
      ena = !(n >= 4 && n < 7);
      @(posedge clk); #1; n++;
    end
    ena = 1;
    chk("latency_ena_gap", n, 13);
    @(posedge clk); #1;

    issue8(100, 200);
    repeat (5) @(posedge clk);
    #1 rst_n = 0;
    void'(q8.pop_back());
    #1;
    chk("midrst_valid", int'(ov8), 0);
    chk("midrst_root", int'(root8), 0);
    chk("midrst_sum", int'(sum8), 0);
    chk("midrst_exact", int'(ex8), 0);
    @(posedge clk); #1 rst_n = 1;
    issue8(7, 24);
    issue8(1, 0);
    issue8(255, 0);

    issue12(2, 3);
    issue12(255, 255);
    issue12(5, 5);
    issue12(0, 0);
    issue12(4095, 4095);
    issue12(4095, 0);
    bp = 1;
    repeat (2000) issue12($urandom_range(0, 4095), $urandom_range(0, 4095));

    n = 0;
    while ((q8.size() + qf.size() + qr.size()) != 0 && n < 2000) begin @(posedge clk); #1; n++; end
    chk("drain_pending", q8.size() + qf.size() + qr.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
